// File: rtl/pico_bus_pkg.sv
// pico_bus_pkg: shared PicoMem bus types and constants
package pico_bus_pkg;
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  localparam logic [3:0] PICO_RD_SEL = 4'b1111;
  localparam logic [31:0] PICO_ERR_RDATA = 32'hDEAD_BEEF;
  localparam logic [31:0] PICO_WB_BASE = 32'hC000_0000;
endpackage

// File: rtl/pico_wb_bridge_if.sv
// pico_wb_bridge_if: PicoMem responder side and Wishbone initiator side signals
interface pico_wb_bridge_if;
  logic mem_s_valid;
  logic mem_s_ready;
  logic [31:0] mem_s_addr;
  logic [31:0] mem_s_wdata;
  logic [3:0] mem_s_wstrb;
  logic [31:0] mem_s_rdata;
  logic wb_cyc_o;
  logic wb_stb_o;
  logic wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0] wb_sel_o;
  logic [31:0] wb_dat_i;
  logic wb_ack_i;
  logic wb_err_i;
  modport slave (
    input mem_s_valid, mem_s_addr, mem_s_wdata, mem_s_wstrb, wb_dat_i, wb_ack_i, wb_err_i,
    output mem_s_ready, mem_s_rdata, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
  );
  modport master (
    output mem_s_valid, mem_s_addr, mem_s_wdata, mem_s_wstrb, wb_dat_i, wb_ack_i, wb_err_i,
    input mem_s_ready, mem_s_rdata, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
  );
endinterface

// File: rtl/pico_wb_err_log.sv
// pico_wb_err_log: sticky record of the first failing access, clearable
module pico_wb_err_log (
  input logic clk,
  input logic reset,
  input logic log_en,
  input logic log_timeout,
  input logic [31:0] log_addr,
  input logic clr,
  output logic sticky,
  output logic timeout,
  output logic [31:0] addr
);
  // capture only into an empty record; a new error beats a same-cycle clear
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sticky <= 1'b0;
      timeout <= 1'b0;
      addr <= '0;
    end else if (log_en && (!sticky || clr)) begin
      sticky <= 1'b1;
      timeout <= log_timeout;
      addr <= log_addr;
    end else if (clr) begin
      sticky <= 1'b0;
      timeout <= 1'b0;
      addr <= '0;
    end
endmodule

// File: rtl/pico_wb_bridge.sv
// pico_wb_bridge: PicoMem responder turning each transfer into one classic Wishbone cycle
module pico_wb_bridge
  import pico_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA = PICO_ERR_RDATA,
  parameter logic [31:0] ADDR_MASK = 32'h3FFF_FFFC
) (
  input logic clk,
  input logic reset,
  pico_wb_bridge_if.slave bus,
  input logic err_clr,
  output logic err_sticky,
  output logic err_timeout,
  output logic [31:0] err_addr
);
  state_t state;
  logic [15:0] cnt;
  logic [31:0] req_addr;
  logic got_err, got_ack, got_to, fail;
  // bus termination decode, err beats ack beats timeout
  always_comb begin
    got_err = state == BUS && bus.wb_err_i;
    got_ack = state == BUS && bus.wb_ack_i && !bus.wb_err_i;
    got_to = state == BUS && !bus.wb_ack_i && !bus.wb_err_i && cnt == 16'(TIMEOUT_CYCLES - 1);
    fail = got_err || got_to;
  end
  // request/response FSM with all bus outputs registered
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      req_addr <= '0;
      bus.wb_cyc_o <= 1'b0;
      bus.wb_stb_o <= 1'b0;
      bus.wb_we_o <= 1'b0;
      bus.wb_adr_o <= '0;
      bus.wb_dat_o <= '0;
      bus.wb_sel_o <= '0;
      bus.mem_s_ready <= 1'b0;
      bus.mem_s_rdata <= '0;
    end else begin
      case (state)
        IDLE: if (bus.mem_s_valid) begin
          req_addr <= bus.mem_s_addr;
          bus.wb_adr_o <= bus.mem_s_addr & ADDR_MASK;
          bus.wb_dat_o <= bus.mem_s_wdata;
          bus.wb_we_o <= |bus.mem_s_wstrb;
          bus.wb_sel_o <= |bus.mem_s_wstrb ? bus.mem_s_wstrb : PICO_RD_SEL;
          bus.wb_cyc_o <= 1'b1;
          bus.wb_stb_o <= 1'b1;
          cnt <= '0;
          state <= BUS;
        end
        BUS: begin
          cnt <= cnt + 16'd1;
          if (fail || got_ack) begin
            bus.wb_cyc_o <= 1'b0;
            bus.wb_stb_o <= 1'b0;
            bus.mem_s_ready <= 1'b1;
            bus.mem_s_rdata <= fail ? ERR_RDATA : bus.wb_we_o ? 32'h0 : bus.wb_dat_i;
            state <= RESP;
          end
        end
        RESP: begin
          bus.mem_s_ready <= 1'b0;
          bus.mem_s_rdata <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  pico_wb_err_log u_log (
    .clk(clk),
    .reset(reset),
    .log_en(fail),
    .log_timeout(got_to),
    .log_addr(req_addr),
    .clr(err_clr),
    .sticky(err_sticky),
    .timeout(err_timeout),
    .addr(err_addr)
  );
endmodule

// File: tb/tb_pico_wb_bridge.sv
// tb_pico_wb_bridge: randomized transaction bench with a timeline-level reference model
module tb_pico_wb_bridge;
  localparam int T = 8;
  localparam logic [31:0] MASK = 32'h3FFF_FFFC;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic err_clr = 1'b0;
  logic err_sticky, err_timeout;
  logic [31:0] err_addr;
  pico_wb_bridge_if b();
  pico_wb_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk),
    .reset(reset),
    .bus(b.slave),
    .err_clr(err_clr),
    .err_sticky(err_sticky),
    .err_timeout(err_timeout),
    .err_addr(err_addr)
  );
  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0, n_txn = 0, n_ready = 0, run = 0, last_len = 0;
  logic chk_en = 1'b0;
  logic e_cyc = 0, e_we = 0, e_ready = 0, e_sticky = 0, e_to = 0;
  logic [3:0] e_sel = 0;
  logic [31:0] e_adr = 0, e_dat = 0, e_rdata = 0, e_eaddr = 0;
  logic [31:0] last_rdata = 0, last_adr = 0;
  logic [3:0] last_sel = 0;
  logic last_we = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, want %h", n, $time, a, e);
    end
  endtask

  // per-cycle comparison against the model, plus a monitor for the literal pins
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc", b.wb_cyc_o, e_cyc);
      chk("stb", b.wb_stb_o, e_cyc);
      chk("ready", b.mem_s_ready, e_ready);
      chk("rdata", b.mem_s_rdata, e_rdata);
      chk("err_sticky", err_sticky, e_sticky);
      chk("err_timeout", err_timeout, e_to);
      chk("err_addr", err_addr, e_eaddr);
      if (e_cyc) begin
        chk("adr", b.wb_adr_o, e_adr);
        chk("dat_o", b.wb_dat_o, e_dat);
        chk("we", b.wb_we_o, e_we);
        chk("sel", b.wb_sel_o, e_sel);
      end
    end
    if (reset) run = 0;
    else if (b.wb_cyc_o) begin
      run++;
      last_adr = b.wb_adr_o;
      last_sel = b.wb_sel_o;
      last_we = b.wb_we_o;
    end
    if (b.mem_s_ready) begin
      n_ready++;
      last_rdata = b.mem_s_rdata;
      last_len = run;
      run = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    e_sticky = 0;
    e_to = 0;
    e_eaddr = 0;
  endtask

  // kind: 0 ack, 1 err, 2 ack+err, 3 silent; w wait cycles before the response
  task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                         input int w, input int kind, input bit drop, input bit clr_end,
                         input logic [31:0] rdv);
    bit resp, tmo, fail;
    int n;
    resp = kind != 3 && w + 1 <= T;
    n = resp ? w + 1 : T;
    tmo = !resp;
    fail = tmo || kind != 0;
    b.mem_s_valid = 1;
    b.mem_s_addr = a;
    b.mem_s_wdata = wd;
    b.mem_s_wstrb = ws;
    b.wb_ack_i = 0;
    b.wb_err_i = 0;
    e_cyc = 0;
    e_ready = 0;
    e_rdata = 0;
    step();
    e_cyc = 1;
    e_adr = a & MASK;
    e_dat = wd;
    e_we = ws != 0;
    e_sel = ws == 0 ? 4'hF : ws;
    for (int c = 1; c <= n; c++) begin
      if (drop) b.mem_s_valid = 0;
      b.wb_dat_i = c == n ? rdv : $urandom;
      b.wb_ack_i = resp && c == n && kind != 1;
      b.wb_err_i = resp && c == n && kind != 0;
      err_clr = c == n && clr_end;
      step();
    end
    if (fail && (!e_sticky || err_clr)) begin
      e_sticky = 1;
      e_to = tmo;
      e_eaddr = a;
    end else if (err_clr) model_clear();
    err_clr = 0;
    n_txn++;
    e_cyc = 0;
    e_ready = 1;
    e_rdata = fail ? 32'hDEAD_BEEF : ws != 0 ? 32'h0 : rdv;
    b.wb_ack_i = 1'($urandom_range(0, 1));
    b.wb_err_i = 1'($urandom_range(0, 1));
    b.wb_dat_i = $urandom;
    step();
    b.mem_s_valid = 0;
    b.wb_ack_i = 0;
    b.wb_err_i = 0;
    e_ready = 0;
    e_rdata = 0;
  endtask

  task automatic idle(input int k, input bit clr);
    for (int i = 0; i < k; i++) begin
      b.wb_ack_i = 1'($urandom_range(0, 1));
      b.wb_err_i = 1'($urandom_range(0, 1));
      err_clr = clr;
      step();
      if (clr) model_clear();
    end
    err_clr = 0;
    b.wb_ack_i = 0;
    b.wb_err_i = 0;
  endtask

  initial begin
    b.mem_s_valid = 0;
    b.mem_s_addr = 0;
    b.mem_s_wdata = 0;
    b.mem_s_wstrb = 0;
    b.wb_dat_i = 0;
    b.wb_ack_i = 0;
    b.wb_err_i = 0;
    chk_en = 1;
    repeat (2) step();
    reset = 0;
    step();
    run_txn(32'hC000_0010, 32'h0, 4'h0, 0, 0, 0, 0, 32'h1234_5678);
    chk("t1_rdata", last_rdata, 32'h1234_5678);
    chk("t1_adr", last_adr, 32'h0000_0010);
    chk("t1_sel", 32'(last_sel), 32'hF);
    chk("t1_we", 32'(last_we), 32'h0);
    chk("t1_len", last_len, 1);
    chk("t1_sticky", 32'(err_sticky), 32'h0);
    run_txn(32'hC000_0104, 32'h00AB_0000, 4'b0100, 5, 0, 0, 0, 32'h5555_AAAA);
    chk("t2_rdata", last_rdata, 32'h0);
    chk("t2_len", last_len, 6);
    chk("t2_sel", 32'(last_sel), 32'h4);
    chk("t2_we", 32'(last_we), 32'h1);
    run_txn(32'hC000_0200, 32'h0, 4'h0, 20, 3, 0, 0, 32'h0);
    chk("t3_len", last_len, 8);
    chk("t3_rdata", last_rdata, 32'hDEAD_BEEF);
    chk("t3_sticky", 32'(err_sticky), 32'h1);
    chk("t3_timeout", 32'(err_timeout), 32'h1);
    chk("t3_addr", err_addr, 32'hC000_0200);
    idle(1, 1);
    chk("clr_sticky", 32'(err_sticky), 32'h0);
    run_txn(32'hC000_0300, 32'h0, 4'h0, 2, 2, 0, 0, 32'h7777_7777);
    chk("t4_rdata", last_rdata, 32'hDEAD_BEEF);
    chk("t4_timeout", 32'(err_timeout), 32'h0);
    run_txn(32'hC000_0400, 32'h1111_2222, 4'hF, 0, 1, 0, 0, 32'h0);
    chk("t4_keep_addr", err_addr, 32'hC000_0300);
    idle(1, 1);
    chk("t4_clr", {err_addr[30:0], err_sticky}, 32'h0);
    chk("t4_clr_to", 32'(err_timeout), 32'h0);
    b.mem_s_valid = 1;
    b.mem_s_addr = 32'hC000_0500;
    b.mem_s_wdata = 0;
    b.mem_s_wstrb = 0;
    step();
    e_cyc = 1;
    e_adr = 32'h0000_0500;
    e_dat = 0;
    e_we = 0;
    e_sel = 4'hF;
    step();
    step();
    #2 reset = 1;
    e_cyc = 0;
    e_ready = 0;
    e_rdata = 0;
    model_clear();
    #1;
    chk("rst_cyc", 32'(b.wb_cyc_o), 32'h0);
    chk("rst_stb", 32'(b.wb_stb_o), 32'h0);
    chk("rst_ready", 32'(b.mem_s_ready), 32'h0);
    chk("rst_adr", b.wb_adr_o, 32'h0);
    b.mem_s_valid = 0;
    step();
    step();
    reset = 0;
    step();
    run_txn(32'hC000_0020, 32'h0, 4'h0, 1, 0, 0, 0, 32'hCAFE_F00D);
    chk("rst_after_rdata", last_rdata, 32'hCAFE_F00D);
    run_txn(32'hC000_0030, 32'h0, 4'h0, 0, 0, 0, 0, 32'hA5A5_0001);
    run_txn(32'hC000_0034, 32'h0102_0304, 4'b0011, 0, 0, 0, 0, 32'hFFFF_FFFF);
    chk("b2b_rdata", last_rdata, 32'h0);
    for (int i = 0; i < 150; i++) begin
      logic [3:0] ws;
      ws = $urandom_range(0, 2) == 0 ? 4'h0 : 4'($urandom);
      run_txn($urandom, $urandom, ws, $urandom_range(0, 9), $urandom_range(0, 3),
              $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, $urandom);
      idle($urandom_range(0, 2), $urandom_range(0, 4) == 0);
    end
    idle(2, 0);
    chk("ready_count", n_ready, n_txn);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
